down_timer_arbiter: RTL and testbench

- Shares one WIDTH-bit down-counter timing resource among N_REQ requesters.
- Each requester asks for a countdown of its own length.
- The block picks one requester round-robin, loads that requester's value into the shared counter and counts down to zero.
- It pulses that requester's done line, then releases the counter for the next requester.
- Sits between the control logic of several clients and the single shared down-counter datapath.

---
 rtl/down_timer_arbiter_if.sv | 29 ++
 rtl/down_timer_arbiter.sv | 164 ++++++++++++++++
 tb/tb_down_timer_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/down_timer_arbiter_if.sv
// Bundle between the client control logic and the shared down-counter
// arbiter. The clients drive requests, per-client lengths and the global
// pause. The arbiter returns grant, done pulse, live count and busy.
interface down_timer_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]       req;       // one request line per client
  logic [N_REQ*WIDTH-1:0] load_val;  // slice i is client i's countdown length
  logic                   hold;      // global pause of the running countdown
  logic [N_REQ-1:0]       grant;     // one-hot owner of the counter
  logic [N_REQ-1:0]       done;      // one-cycle expiry pulse to the owner
  logic [WIDTH-1:0]       count;     // live value of the shared counter
  logic                   busy;      // arbiter is not idle

  // Client side: issues requests and observes the outcome.
  modport master (
    output req, load_val, hold,
    input  grant, done, count, busy
  );

  // Arbiter side: consumes requests and owns the counter outputs.
  modport slave (
    input  req, load_val, hold,
    output grant, done, count, busy
  );

endinterface

// File: rtl/down_timer_arbiter.sv
// Round-robin owner of one shared WIDTH-bit down-counter.
// A client is picked in IDLE, its length is loaded and counted to zero in
// COUNT, and a one-cycle done pulse is raised in DONE before the counter is
// released. The owner may abort by dropping req, and hold pauses the count.
module down_timer_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  down_timer_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Registered state and outputs
  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic [WIDTH-1:0] r_count;
  logic [IDX_W-1:0] r_last;

  // Next values
  state_t           w_state_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [N_REQ-1:0] w_done_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [IDX_W-1:0] w_last_nxt;

  // Arbitration and decode helpers
  logic [WIDTH-1:0] w_load [N_REQ];
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_win;
  logic             w_any_req;
  logic [N_REQ-1:0] w_win_onehot;
  logic             w_owner_req;
  logic             w_expired;

  // Split the flat length bus into one entry per client.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_load[i] = bus.load_val[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first active request after the last winner, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    w_cand    = '0;
    w_win     = r_last;
    w_any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % N_REQ);
      if (!w_any_req && bus.req[w_cand]) begin
        w_any_req = 1'b1;
        w_win     = w_cand;
      end
    end
  end

  assign w_win_onehot = N_REQ'(1) << w_win;
  // The owner still wants the counter only while its own req stays high.
  assign w_owner_req  = |(bus.req & r_grant);
  assign w_expired    = (r_count == '0);

  // State register together with the registered outputs and the pointer.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the
    // pre-edge values, independent of statement order.
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_count <= '1;
      r_last  <= IDX_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_count <= w_count_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic: abort beats hold, hold beats expiry.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!w_owner_req) begin
          w_state_nxt = S_IDLE;
        end else if (bus.hold) begin
          w_state_nxt = S_COUNT;
        end else if (w_expired) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of grant, done, counter and pointer.
  always_comb begin
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_count_nxt = r_count;
    w_last_nxt  = r_last;
    unique case (r_state)
      S_IDLE: begin
        // Lengths are captured only here; later load_val changes are ignored.
        if (w_any_req) begin
          w_grant_nxt = w_win_onehot;
          w_count_nxt = w_load[w_win];
          w_last_nxt  = w_win;
        end else begin
          w_grant_nxt = '0;
        end
      end
      S_COUNT: begin
        if (!w_owner_req) begin
          // Abort keeps the counter where it stopped and gives no done.
          w_grant_nxt = '0;
        end else if (bus.hold) begin
          w_count_nxt = r_count;
        end else if (w_expired) begin
          // Grant stays up alongside the done pulse.
          w_done_nxt = r_grant;
        end else begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end
      S_DONE: begin
        w_grant_nxt = '0;
        w_count_nxt = '0;
      end
      default: begin
        w_grant_nxt = '0;
      end
    endcase
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.count = r_count;
  assign bus.busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_down_timer_arbiter.sv
// Bench for down_timer_arbiter: a transaction-level reference model predicts
// grant/done/count/busy each cycle into a queue that a monitor drains and
// compares; directed scenarios add latency and ordering checks on top, then
// a long randomized phase exercises requests, aborts, hold and reset.
module tb_down_timer_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  logic clk;
  logic reset;

  down_timer_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

  down_timer_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: who owns the counter (-1 = nobody), whether its done
  // pulse is showing, the counter value and the last winner.
  typedef struct packed {
    int             owner;
    bit             fin;
    logic [W-1:0]   cnt;
    int             last;
  } model_t;

  function automatic model_t model_step(model_t m, logic rst, logic [N-1:0] req,
                                        logic [N*W-1:0] lv, logic hold);
    model_t r = m;
    bit found = 1'b0;
    int i;
    if (rst) begin
      r.owner = -1; r.fin = 1'b0; r.cnt = '1; r.last = N - 1;
    end else if (m.fin) begin
      r.owner = -1; r.fin = 1'b0; r.cnt = '0;
    end else if (m.owner >= 0) begin
      if (!req[m.owner]) r.owner = -1;
      else if (!hold) begin
        if (m.cnt == 0) r.fin = 1'b1;
        else r.cnt = W'(m.cnt - 1);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        i = (m.last + k) % N;
        if (!found && req[i]) begin
          found = 1'b1; r.owner = i; r.cnt = lv[i*W +: W]; r.last = i;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [2*N+W:0] model_out(model_t m);
    logic [N-1:0] g;
    g = (m.owner >= 0) ? (N'(1) << m.owner) : '0;
    return {g, (m.fin ? g : {N{1'b0}}), m.cnt, (m.owner >= 0)};
  endfunction

  logic [2*N+W:0] exp_q [$];
  model_t m;

  // Model: advance on each edge using the same sampled inputs as the DUT.
  initial begin
    m.owner = -1; m.fin = 1'b0; m.cnt = '0; m.last = N - 1;
    forever begin
      @(posedge clk);
      m = model_step(m, reset, bus.req, bus.load_val, bus.hold);
      exp_q.push_back(model_out(m));
    end
  end

  // Monitor: compare every presented output set against the scoreboard.
  initial begin
    logic [2*N+W:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_outputs", 32'({bus.grant, bus.done, bus.count, bus.busy}), 32'(e));
      end
    end
  end

  task automatic set_load(input int idx, input int v);
    bus.load_val[idx*W +: W] = v[W-1:0];
  endtask

  // One-cycle reset; returns at the negedge after it, with reset values checked.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_grant", bus.grant, 0);
    check("reset_done",  bus.done, 0);
    check("reset_busy",  bus.busy, 0);
    check("reset_count", bus.count, 4'hF);
  endtask

  // Single requester countdown with latency and count sequence checks.
  task automatic run_one(input int idx, input int v);
    int n = 0;
    bit seen = 1'b0;
    bus.req = N'(1) << idx;
    set_load(idx, v);
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) check("first_grant", bus.grant, 1 << idx);
      if (n <= v + 1) check("count_seq", bus.count, v - n + 1);
      if (bus.done != 0) seen = 1'b1;
    end
    check("done_latency", n, v + 2);
    check("done_bit", bus.done, 1 << idx);
    bus.req = '0;
    @(negedge clk);
    check("post_done_busy", bus.busy, 0);
    check("post_done_count", bus.count, 0);
    check("post_done_grant", bus.grant, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rr_exp [5];
    logic [N-1:0] prev;
    logic [N-1:0] act;
    int n, gi, len, idle, cyc, hold_left;
    bit seen, started, found;

    reset = 1'b1;
    bus.req = '0;
    bus.load_val = '0;
    bus.hold = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request, length 3.
    run_one(0, 3);

    // Round-robin with all lengths 1.
    do_reset();
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.load_val = 16'h1111;
    bus.req = 4'b1111;
    gi = 0; len = 0; idle = 0; cyc = 0; prev = '0;
    while (gi < 5 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (bus.grant != 0) begin
        if (prev == 0) begin
          check("rr_order", bus.grant, rr_exp[gi]);
          if (gi > 0) check("rr_gap", idle, 1);
          gi++; len = 0; idle = 0;
        end
        len++;
      end else begin
        if (prev != 0) check("rr_len", len, 3);
        idle++;
      end
      prev = bus.grant;
    end
    if (gi < 5) check("rr_timeout", gi, 5);
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Zero and maximum lengths.
    run_one(2, 0);
    run_one(1, 15);

    // Hold for 4 cycles once the count reaches 3.
    bus.req = 4'b0001;
    set_load(0, 5);
    n = 0; seen = 1'b0; started = 1'b0; hold_left = 0;
    while (!seen && n < 60) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (hold_left > 0) begin
        check("hold_count", bus.count, 3);
        hold_left--;
        if (hold_left == 0) bus.hold = 1'b0;
      end else if (!started && bus.count == 3 && bus.grant == 4'b0001) begin
        started = 1'b1; bus.hold = 1'b1; hold_left = 4;
      end
      if (bus.done != 0) seen = 1'b1;
    end
    check("hold_done_latency", n, 11);
    bus.req = '0;
    bus.hold = 1'b0;
    @(negedge clk);

    // Abort by requester 3 at count 6, with requester 0 pending.
    bus.req = 4'b1000;
    set_load(3, 9);
    set_load(0, 2);
    found = 1'b0; cyc = 0;
    while (!found && cyc < 30) begin
      @(negedge clk); cyc++;
      if (bus.grant == 4'b1000 && bus.count == 6) found = 1'b1;
    end
    check("abort_reach", found, 1);
    bus.req = 4'b0001;
    @(negedge clk);
    check("abort_grant", bus.grant, 0);
    check("abort_done", bus.done, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_count", bus.count, 6);
    @(negedge clk);
    check("abort_next_grant", bus.grant, 4'b0001);
    check("abort_next_count", bus.count, 2);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk); cyc++;
      if (bus.done != 0) seen = 1'b1;
    end
    check("abort_next_done", seen, 1);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a countdown.
    bus.req = 4'b0010;
    set_load(1, 8);
    found = 1'b0; cyc = 0;
    while (!found && cyc < 30) begin
      @(negedge clk); cyc++;
      if (bus.grant == 4'b0010 && bus.count == 4) found = 1'b1;
    end
    check("midreset_reach", found, 1);
    bus.req = 4'b1111;
    do_reset();
    @(negedge clk);
    check("midreset_priority", bus.grant, 4'b0001);
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic: requests held until done or random abort,
    // lengths changing every cycle, random hold and rare resets.
    act = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i]) begin
          if ($urandom_range(5) == 0) act[i] = 1'b1;
        end else if (bus.done[i]) begin
          if ($urandom_range(1) == 0) act[i] = 1'b0;
        end else if ($urandom_range(49) == 0) begin
          act[i] = 1'b0;
        end
      end
      bus.req = act;
      bus.load_val = 16'($urandom);
      bus.hold = ($urandom_range(7) == 0);
      reset = ($urandom_range(399) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    bus.req = '0;
    bus.hold = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
